// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// the PC register index, and one shadow-scoreboard entry.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [3:0] REG_PC = 4'hF;

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic       regwrite;
    logic       memtoreg;
    logic [3:0] ra1;
    logic [3:0] ra2;
  } sb_entry_t;

  // Memory-stage result wins over writeback; R15 always comes from the regfile.
  function automatic fwd_sel_t fwd_select(input logic [3:0] ra,
                                          input sb_entry_t m,
                                          input sb_entry_t w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra != REG_PC) begin
      if (m.valid && m.regwrite && (m.rd == ra))
        sel = FWD_M;
      else if (w.valid && w.regwrite && (w.rd == ra))
        sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sb_stage.sv
// One shadow-scoreboard register: holds on hold, loads a bubble on bubble,
// and ANDs the incoming regwrite with rw_gate.
module sb_stage
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      hold,
  input  logic      bubble,
  input  logic      rw_gate,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (!hold) begin
      q          <= d;
      q.valid    <= d.valid & ~bubble;
      q.regwrite <= d.regwrite & rw_gate;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside decode: tracks E/M/W in a shadow scoreboard and
// drives stalls, flushes, Execute forwarding selects and a stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RdD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             CondExE,
  input  logic             BranchTakenE,
  input  logic             MemStall,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount
);

  sb_entry_t d_entry;
  sb_entry_t e_q;
  sb_entry_t m_q;
  sb_entry_t w_q;
  logic      ld_use;
  fwd_sel_t  fwd_a;
  fwd_sel_t  fwd_b;

  always_comb begin
    d_entry          = '0;
    d_entry.valid    = 1'b1;
    d_entry.rd       = RdD;
    d_entry.regwrite = RegWriteD;
    d_entry.memtoreg = MemtoRegD;
    d_entry.ra1      = RA1D;
    d_entry.ra2      = RA2D;
  end

  // Conservative: a predicated-off load still stalls its consumer.
  assign ld_use = e_q.valid & e_q.regwrite & e_q.memtoreg &
                  ((e_q.rd == RA1D) | (e_q.rd == RA2D));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (MemStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (ld_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  sb_stage u_sb_e (
    .clk     (clk),
    .reset   (reset),
    .hold    (MemStall),
    .bubble  (FlushE),
    .rw_gate (1'b1),
    .d       (d_entry),
    .q       (e_q)
  );

  sb_stage u_sb_m (
    .clk     (clk),
    .reset   (reset),
    .hold    (MemStall),
    .bubble  (1'b0),
    .rw_gate (CondExE & e_q.valid),
    .d       (e_q),
    .q       (m_q)
  );

  sb_stage u_sb_w (
    .clk     (clk),
    .reset   (reset),
    .hold    (MemStall),
    .bubble  (1'b0),
    .rw_gate (1'b1),
    .d       (m_q),
    .q       (w_q)
  );

  assign fwd_a     = fwd_select(e_q.ra1, m_q, w_q);
  assign fwd_b     = fwd_select(e_q.ra2, m_q, w_q);
  assign ForwardAE = reset ? FWD_RF : fwd_a;
  assign ForwardBE = reset ? FWD_RF : fwd_b;

  always_ff @(posedge clk) begin
    if (reset)
      StallCount <= '0;
    else if (StallD && (StallCount != {CNT_W{1'b1}}))
      StallCount <= StallCount + 1'b1;
  end

  // Source fields travel with M and W for symmetry but only E's are read.
  logic unused_fields;
  assign unused_fields = ^{m_q.memtoreg, m_q.ra1, m_q.ra2,
                           w_q.memtoreg, w_q.ra1, w_q.ra2};

endmodule
